// File: rtl/pkt_pkg.sv
// rtl/pkt_pkg.sv - shared FSM state and packet field positions for packet_union_fifo
package pkt_pkg;

  // Two-state control: normal operation and a single-cycle flush.
  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // Field positions inside a raw bus word; the address occupies the top ADDR_W bits.
  localparam int VALID_BIT = 0;
  localparam int DATA_LSB  = 1;

endpackage

// File: rtl/pkt_fifo_mem.sv
// rtl/pkt_fifo_mem.sv - DEPTH x W packet storage, one write port, asynchronous read port
module pkt_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int W     = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  // Contents are qualified by the controller's level, so the array needs no reset.
  logic [W-1:0] mem [DEPTH];

  // Write the incoming packet at the write pointer.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/packet_union_fifo.sv
// rtl/packet_union_fifo.sv - packet view of bus words with drop filtering and FWFT buffering; optional PKT_ADDR_FILTER_EN
module packet_union_fifo
  import pkt_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_W+DATA_W:0]     in_word,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_W-1:0]          out_addr,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CNT_W-1:0]           drop_cnt
`ifdef PKT_ADDR_FILTER_EN
  ,
  input  logic [ADDR_W-1:0]          cfg_addr,
  input  logic [ADDR_W-1:0]          cfg_mask
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + DATA_W;

  // Field-level overlay of the raw producer word.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              valid;
  } pkt_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  pkt_t             in_pkt;
  entry_t           head;
  logic [ENT_W-1:0] rd_word;
  state_t           state;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             addr_ok;
  logic             push;
  logic             pop;
  logic             store;
  logic             drop;

  assign in_pkt = in_word;

`ifdef PKT_ADDR_FILTER_EN
  assign addr_ok = ((in_pkt.addr ^ cfg_addr) & cfg_mask) == '0;
`else
  assign addr_ok = 1'b1;
`endif

  // Full is judged from level so a pop in the same cycle never frees a slot early.
  assign in_ready  = !rst && (state == RUN) && (level < LVL_W'(DEPTH));
  assign out_valid = (state == RUN) && (level != '0);

  // A flush request blocks both handshakes in the cycle it is seen.
  assign push  = in_valid && in_ready && !flush;
  assign pop   = out_valid && out_ready && !flush;
  assign store = push && in_pkt.valid && addr_ok;
  assign drop  = push && !store;

  pkt_fifo_mem #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_mem (
    .clk   (clk),
    .we    (store),
    .waddr (wr_ptr),
    .wdata ({in_pkt.addr, in_pkt.data}),
    .raddr (rd_ptr),
    .rdata (rd_word)
  );

  assign head     = rd_word;
  assign out_addr = out_valid ? head.addr : '0;
  assign out_data = out_valid ? head.data : '0;

  // Control FSM, queue pointers, occupancy and saturating drop counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      drop_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (flush) begin
            state    <= FLUSH;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            drop_cnt <= '0;
          end else begin
            if (store) begin
              wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
              rd_ptr <= rd_ptr + 1'b1;
            end
            if (store && !pop) begin
              level <= level + 1'b1;
            end else if (pop && !store) begin
              level <= level - 1'b1;
            end
            if (drop && (drop_cnt != '1)) begin
              drop_cnt <= drop_cnt + 1'b1;
            end
          end
        end
        FLUSH: begin
          state    <= RUN;
          wr_ptr   <= '0;
          rd_ptr   <= '0;
          level    <= '0;
          drop_cnt <= '0;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_union_fifo.sv
// tb/tb_packet_union_fifo.sv - scoreboard bench for packet_union_fifo against a queue-based reference model
module tb_packet_union_fifo;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;
  localparam int W      = ADDR_W + DATA_W + 1;
  localparam int E      = ADDR_W + DATA_W;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [W-1:0]      in_word = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic [$clog2(DEPTH):0] level;
  logic [CNT_W-1:0]  drop_cnt;
`ifdef PKT_ADDR_FILTER_EN
  logic [ADDR_W-1:0] cfg_addr = 8'hA0;
  logic [ADDR_W-1:0] cfg_mask = 8'hF0;
`endif

  packet_union_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .level     (level),
    .drop_cnt  (drop_cnt)
`ifdef PKT_ADDR_FILTER_EN
    ,
    .cfg_addr  (cfg_addr),
    .cfg_mask  (cfg_mask)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue of stored packets plus a drop tally.
  logic [E-1:0] exp_q[$];
  int           exp_drop = 0;
  bit           flushing = 0;
  bit           acc_ok = 0;
  int           errors = 0;
  int           checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit addr_pass(input logic [W-1:0] w);
`ifdef PKT_ADDR_FILTER_EN
    return (((w[W-1 -: ADDR_W] ^ cfg_addr) & cfg_mask) == '0);
`else
    return (w[W-1] === 1'b0) || (w[W-1] === 1'b1);
`endif
  endfunction

  // Monitor: compares DUT outputs with the model, consumes the head on a pop.
  always @(negedge clk) begin
    bit e_rdy, e_ov;
    logic [E-1:0] h;
    if (rst) begin
      acc_ok = 0;
    end else begin
      e_rdy = !flushing && (exp_q.size() < DEPTH);
      e_ov  = !flushing && (exp_q.size() != 0);
      chk("in_ready", 32'(in_ready), 32'(e_rdy));
      chk("out_valid", 32'(out_valid), 32'(e_ov));
      chk("level", 32'(level), 32'(exp_q.size()));
      chk("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
      if (e_ov) begin
        h = exp_q[0];
        chk("out_addr", 32'(out_addr), 32'(h[E-1 -: ADDR_W]));
        chk("out_data", 32'(out_data), 32'(h[DATA_W-1:0]));
      end else begin
        chk("out_addr_idle", 32'(out_addr), 32'h0);
        chk("out_data_idle", 32'(out_data), 32'h0);
      end
      if (flushing) begin
        flushing = 0;
        acc_ok   = 0;
      end else if (flush) begin
        exp_q.delete();
        exp_drop = 0;
        flushing = 1;
        acc_ok   = 0;
      end else begin
        if (e_ov && out_ready) void'(exp_q.pop_front());
        acc_ok = e_rdy && in_valid;
      end
    end
  end

  // Drive one cycle of stimulus, then record the expected effect of an accepted word.
  task automatic step(input logic iv, input logic [W-1:0] w, input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    in_valid  = iv;
    in_word   = w;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    #1;
    if (acc_ok) begin
      if (w[0] && addr_pass(w)) exp_q.push_back(w[W-1:1]);
      else if (exp_drop < CMAX) exp_drop++;
    end
  endtask

  function automatic logic [W-1:0] mk(input logic [7:0] a, input logic [7:0] d, input logic v);
    return {a, d, v};
  endfunction

  initial begin
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_level", 32'(level), 32'h0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single packet appears one cycle after acceptance.
    step(1, mk(8'h12, 8'h34, 1), 0, 0);
    step(0, '0, 0, 0);
    chk("t1_level", 32'(level), 32'h1);
    chk("t1_addr", 32'(out_addr), 32'h12);
    chk("t1_data", 32'(out_data), 32'h34);

    // Fill to DEPTH, fifth word is held until a pop frees a slot.
    for (int i = 0; i < 3; i++) step(1, mk(8'h20 + 8'(i), 8'h40 + 8'(i), 1), 0, 0);
    step(1, mk(8'h55, 8'h66, 1), 0, 0);
    chk("t2_full_level", 32'(level), 32'h4);
    chk("t2_full_ready", 32'(in_ready), 32'h0);
    step(1, mk(8'h55, 8'h66, 1), 1, 0);
    step(1, mk(8'h55, 8'h66, 1), 0, 0);
    step(0, '0, 0, 0);
    chk("t2_refill_level", 32'(level), 32'h4);
    for (int i = 0; i < 5; i++) step(0, '0, 1, 0);

    // Invalid words are counted, then the counter saturates.
    for (int i = 0; i < 3; i++) step(1, mk(8'h01, 8'h02, 0), 0, 0);
    step(0, '0, 0, 0);
    chk("t3_drop3", 32'(drop_cnt), 32'h3);
    chk("t3_level", 32'(level), 32'h0);
    for (int i = 0; i < 6; i++) step(1, mk(8'h03, 8'h04, 0), 0, 0);
    step(0, '0, 0, 0);
    chk("t3_drop_sat", 32'(drop_cnt), 32'(CMAX));

    // Steady push+pop at level 2 across pointer wrap.
    step(1, mk(8'h70, 8'h80, 1), 0, 0);
    step(1, mk(8'h71, 8'h81, 1), 0, 0);
    for (int i = 0; i < 6; i++) step(1, mk(8'h90 + 8'(i), 8'hA0 + 8'(i), 1), 1, 0);
    step(0, '0, 0, 0);
    chk("t4_level", 32'(level), 32'h2);

    // Flush from level 3 clears everything, pushes resume after the flush cycle.
    step(1, mk(8'h77, 8'h88, 1), 0, 0);
    step(0, '0, 0, 1);
    step(0, '0, 0, 0);
    chk("t5_level", 32'(level), 32'h0);
    chk("t5_drop", 32'(drop_cnt), 32'h0);
    chk("t5_out_valid", 32'(out_valid), 32'h0);
    step(1, mk(8'h3C, 8'h5A, 1), 0, 0);
    step(0, '0, 0, 0);
    chk("t5_resume", 32'(level), 32'h1);

`ifdef PKT_ADDR_FILTER_EN
    step(1, mk(8'hA5, 8'h11, 1), 0, 0);
    step(1, mk(8'hB5, 8'h22, 1), 0, 0);
    step(0, '0, 0, 0);
    chk("t6_level", 32'(level), 32'h2);
    chk("t6_drop", 32'(drop_cnt), 32'h1);
`endif

    // Asynchronous reset mid-stream.
    step(1, mk(8'hA1, 8'h33, 1), 0, 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_level", 32'(level), 32'h0);
    chk("arst_out_valid", 32'(out_valid), 32'h0);
    chk("arst_in_ready", 32'(in_ready), 32'h0);
    chk("arst_drop", 32'(drop_cnt), 32'h0);
    exp_q.delete();
    exp_drop = 0;
    flushing = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [W-1:0] w;
      w = W'({$urandom, $urandom});
      w[0] = ($urandom_range(3) != 0);
`ifdef PKT_ADDR_FILTER_EN
      if ($urandom_range(1) == 1) w[W-1 -: 4] = 4'hA;
`endif
      step($urandom_range(9) < 7, w, $urandom_range(1) == 1, $urandom_range(31) == 0);
    end
    step(0, '0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
